// File: rtl/cpu_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_loader
//  Description : Streams program/data words into the mini MIPS CPU memories,
//                then releases the CPU from reset for a bounded run.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_loader #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned RUN_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sel,
    input  logic              s_last,
    input  logic              halt,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] cpu_inst_data,
    output logic              cpu_write_instruction,
    output logic              cpu_write_data,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              err_overflow,
    output logic [ADDR_W:0]   load_count,
    output logic [31:0]       run_count
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_run    = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam bit              c_limited   = (RUN_CYCLES != 0);
    localparam logic [32:0]     c_run_limit = 33'(RUN_CYCLES);
    localparam logic [ADDR_W:0] c_cnt_one   = (ADDR_W+1)'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_settle;
    logic [ADDR_W:0]   r_iaddr;
    logic [ADDR_W:0]   r_daddr;
    logic [ADDR_W:0]   r_load_count;
    logic [31:0]       r_run_count;
    logic [ADDR_W-1:0] r_cpu_address;
    logic [DATA_W-1:0] r_cpu_inst_data;
    logic              r_wr_inst;
    logic              r_wr_data;
    logic              r_halted;
    logic              r_err_overflow;

    logic              w_in_load;
    logic              w_in_run;
    logic              w_start;
    logic              w_xfer;
    logic [ADDR_W:0]   w_sel_cnt;
    logic              w_room;
    logic [32:0]       w_run_next;
    logic              w_run_end;

    assign w_in_load  = (r_state == c_st_load);
    assign w_in_run   = (r_state == c_st_run);
    assign w_start    = start & ((r_state == c_st_idle) | (r_state == c_st_done));
    assign w_xfer     = s_valid & w_in_load;
    assign w_sel_cnt  = s_sel ? r_daddr : r_iaddr;
    // Counter MSB set means the selected memory has already been filled
    assign w_room     = ~w_sel_cnt[ADDR_W];
    assign w_run_next = {1'b0, r_run_count} + 33'd1;
    assign w_run_end  = w_in_run & (halt | (c_limited & (w_run_next == c_run_limit)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) w_state_nxt = c_st_load;
            end
            c_st_load: begin
                if (w_xfer && s_last) w_state_nxt = c_st_settle;
            end
            c_st_settle: begin
                if (r_settle) w_state_nxt = c_st_run;
            end
            c_st_run: begin
                if (w_run_end) w_state_nxt = c_st_done;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_settle        <= 1'b0;
            r_iaddr         <= '0;
            r_daddr         <= '0;
            r_load_count    <= '0;
            r_run_count     <= '0;
            r_cpu_address   <= '0;
            r_cpu_inst_data <= '0;
            r_wr_inst       <= 1'b0;
            r_wr_data       <= 1'b0;
            r_halted        <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_wr_inst <= 1'b0;
            r_wr_data <= 1'b0;

            if (w_start) begin
                r_iaddr        <= '0;
                r_daddr        <= '0;
                r_load_count   <= '0;
                r_run_count    <= '0;
                r_halted       <= 1'b0;
                r_err_overflow <= 1'b0;
            end

            if (w_xfer) begin
                if (w_room) begin
                    r_cpu_address   <= w_sel_cnt[ADDR_W-1:0];
                    r_cpu_inst_data <= s_data;
                    if (s_sel) begin
                        r_wr_data <= 1'b1;
                        r_daddr   <= r_daddr + c_cnt_one;
                    end else begin
                        r_wr_inst <= 1'b1;
                        r_iaddr   <= r_iaddr + c_cnt_one;
                    end
                    if (r_load_count != '1) begin
                        r_load_count <= r_load_count + c_cnt_one;
                    end
                end else begin
                    r_err_overflow <= 1'b1;
                end
            end

            // Two-cycle settle: toggles 0 -> 1 while in SETTLE, leaves on 1
            if (r_state == c_st_settle) begin
                r_settle <= ~r_settle;
            end else begin
                r_settle <= 1'b0;
            end

            if (w_in_run) begin
                if (r_run_count != 32'hFFFF_FFFF) begin
                    r_run_count <= r_run_count + 32'd1;
                end
                if (halt) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign s_ready               = w_in_load;
    assign cpu_rst               = ~w_in_run;
    assign busy                  = w_in_load | (r_state == c_st_settle) | w_in_run;
    assign done                  = (r_state == c_st_done);
    assign cpu_address           = r_cpu_address;
    assign cpu_inst_data         = r_cpu_inst_data;
    assign cpu_write_instruction = r_wr_inst;
    assign cpu_write_data        = r_wr_data;
    assign halted                = r_halted;
    assign err_overflow          = r_err_overflow;
    assign load_count            = r_load_count;
    assign run_count             = r_run_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_loader
//  Description : Scoreboard bench for cpu_loader (default and ADDR_W=2 units).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, s_valid, s_sel, s_last, halt;
    logic [31:0] s_data;

    logic        a_s_ready, a_cpu_rst, a_wi, a_wd, a_busy, a_done, a_halted, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_data;
    logic [10:0] a_lc;
    logic [31:0] a_rc;

    logic        b_s_ready, b_cpu_rst, b_wi, b_wd, b_busy, b_done, b_halted, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_data;
    logic [2:0]  b_lc;
    logic [31:0] b_rc;

    cpu_loader #(.DATA_W(32), .ADDR_W(10), .RUN_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .halt(halt), .cpu_rst(a_cpu_rst),
        .cpu_address(a_addr), .cpu_inst_data(a_data), .cpu_write_instruction(a_wi),
        .cpu_write_data(a_wd), .busy(a_busy), .done(a_done), .halted(a_halted),
        .err_overflow(a_err), .load_count(a_lc), .run_count(a_rc)
    );

    cpu_loader #(.DATA_W(32), .ADDR_W(2), .RUN_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .halt(halt), .cpu_rst(b_cpu_rst),
        .cpu_address(b_addr), .cpu_inst_data(b_data), .cpu_write_instruction(b_wi),
        .cpu_write_data(b_wd), .busy(b_busy), .done(b_done), .halted(b_halted),
        .err_overflow(b_err), .load_count(b_lc), .run_count(b_rc)
    );

    typedef struct {
        logic        sel;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t ea, eb;
    int  n_vec = 0;
    int  n_err = 0;
    int  a_low = 0;

    // Monitors: every strobe pops one expected write
    always @(negedge clk) begin
        if (a_wi | a_wd) begin
            n_vec++;
            if (a_wi & a_wd) begin
                n_err++;
                $display("FAIL a_both_strobes: got wi=%0b wd=%0b, required at most one", a_wi, a_wd);
            end else if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_write: got sel=%0b addr=%0d data=%h, required none", a_wd, a_addr, a_data);
            end else begin
                ea = qa.pop_front();
                if (ea.sel !== a_wd || ea.addr != int'(a_addr) || ea.data !== a_data) begin
                    n_err++;
                    $display("FAIL a_write: got sel=%0b addr=%0d data=%h, required sel=%0b addr=%0d data=%h",
                             a_wd, a_addr, a_data, ea.sel, ea.addr, ea.data);
                end
            end
        end
        if (a_cpu_rst === 1'b0) a_low++;
    end

    always @(negedge clk) begin
        if (b_wi | b_wd) begin
            n_vec++;
            if (b_wi & b_wd) begin
                n_err++;
                $display("FAIL b_both_strobes: got wi=%0b wd=%0b, required at most one", b_wi, b_wd);
            end else if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_write: got sel=%0b addr=%0d data=%h, required none", b_wd, b_addr, b_data);
            end else begin
                eb = qb.pop_front();
                if (eb.sel !== b_wd || eb.addr != int'(b_addr) || eb.data !== b_data) begin
                    n_err++;
                    $display("FAIL b_write: got sel=%0b addr=%0d data=%h, required sel=%0b addr=%0d data=%h",
                             b_wd, b_addr, b_data, eb.sel, eb.addr, eb.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input bit to_b);
        @(posedge clk); #1;
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        chk(to_b ? "b_ready_after_start" : "a_ready_after_start", to_b ? b_s_ready : a_s_ready, 1);
    endtask

    task automatic send_word(input bit to_b, input bit sel, input logic [31:0] data,
                             input bit last, input bit wr, input int addr);
        int  n;
        wr_t e;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = data;
        s_sel   = sel;
        s_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(to_b ? b_s_ready : a_s_ready) && n < 50);
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got s_ready=0, required 1 within 50 cycles");
        end
        if (wr) begin
            e.sel  = sel;
            e.addr = addr;
            e.data = data;
            if (to_b) qb.push_back(e); else qa.push_back(e);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_done(input bit to_b, input int limit);
        int n = 0;
        while (!(to_b ? b_done : a_done) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(to_b ? "b_done_reached" : "a_done_reached", to_b ? b_done : a_done, 1);
    endtask

    task automatic wait_run(input bit to_b, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((to_b ? b_cpu_rst : a_cpu_rst) && n < limit);
        chk(to_b ? "b_run_reached" : "a_run_reached", to_b ? b_cpu_rst : a_cpu_rst, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; s_valid = 1'b0;
        s_sel = 1'b0; s_last = 1'b0; halt = 1'b0; s_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", a_cpu_rst, 1);
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_load_count", a_lc, 0);
        chk("rst_run_count", a_rc, 0);
        chk("rst_strobes", {a_wi, a_wd}, 0);
        chk("rst_address", a_addr, 0);
        chk("rst_err_halted", {a_err, a_halted}, 0);
        chk("rst_b_cpu_rst", b_cpu_rst, 1);
        rst = 1'b1;

        // s_valid held high in IDLE is never accepted
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_s_ready", a_s_ready, 0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;

        // Nine instruction words, full 16-cycle run
        a_low = 0;
        do_start(0);
        for (int i = 0; i < 9; i++) send_word(0, 0, 32'h07E0_000A + i, i == 8, 1, i);
        @(negedge clk);
        chk("settle1_cpu_rst", a_cpu_rst, 1);
        chk("settle1_busy", a_busy, 1);
        @(negedge clk);
        chk("settle2_cpu_rst", a_cpu_rst, 1);
        @(negedge clk);
        chk("run_cpu_rst", a_cpu_rst, 0);
        wait_done(0, 100);
        chk("t1_load_count", a_lc, 9);
        chk("t1_run_count", a_rc, 16);
        chk("t1_cpu_rst_low_cycles", a_low, 16);
        chk("t1_halted", a_halted, 0);
        chk("t1_busy", a_busy, 0);
        chk("t1_cpu_rst_done", a_cpu_rst, 1);

        // Interleaved I/D with gaps
        do_start(0);
        send_word(0, 0, 32'h1111_1111, 0, 1, 0);
        send_word(0, 1, 32'hD000_0000, 0, 1, 0);
        gap(2);
        send_word(0, 0, 32'h2222_2222, 0, 1, 1);
        gap(3);
        send_word(0, 1, 32'hD000_0001, 1, 1, 1);
        @(negedge clk);
        chk("t2_load_count", a_lc, 4);
        wait_done(0, 100);
        chk("t2_run_count", a_rc, 16);

        // Halt at run_count 3
        do_start(0);
        send_word(0, 0, 32'hCAFE_0001, 1, 1, 0);
        wait_run(0, 10);
        chk("t3_run_start", a_rc, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_run_before_halt", a_rc, 3);
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        chk("t3_done", a_done, 1);
        chk("t3_run_count", a_rc, 4);
        chk("t3_halted", a_halted, 1);
        chk("t3_cpu_rst", a_cpu_rst, 1);

        // Halt coinciding with the cycle limit
        do_start(0);
        chk("t4_halted_cleared", a_halted, 0);
        send_word(0, 0, 32'hCAFE_0002, 1, 1, 0);
        wait_run(0, 10);
        repeat (15) @(posedge clk);
        #1;
        chk("t4_run_before_halt", a_rc, 15);
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        chk("t4_done", a_done, 1);
        chk("t4_halted", a_halted, 1);
        chk("t4_run_count", a_rc, 16);

        // Overflow on the 4-word unit
        do_start(1);
        for (int i = 0; i < 5; i++) send_word(1, 0, 32'h0B00_0000 + i, i == 4, i < 4, i);
        @(negedge clk);
        chk("t5_err_overflow", b_err, 1);
        chk("t5_load_count", b_lc, 4);
        chk("t5_settle_cpu_rst", b_cpu_rst, 1);
        wait_run(1, 10);
        wait_done(1, 100);
        chk("t5_run_count", b_rc, 16);
        chk("t5_err_sticky", b_err, 1);

        // Reset mid-LOAD then reload from address 0
        do_start(0);
        for (int i = 0; i < 3; i++) send_word(0, 0, 32'h5555_0000 + i, 0, 1, i);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_s_ready", a_s_ready, 0);
        chk("t6_cpu_rst", a_cpu_rst, 1);
        chk("t6_load_count", a_lc, 0);
        chk("t6_busy", a_busy, 0);
        chk("t6_done", a_done, 0);
        chk("t6_strobes", {a_wi, a_wd}, 0);
        do_start(0);
        send_word(0, 0, 32'hABCD_0000, 1, 1, 0);
        wait_done(0, 100);
        chk("t6_reload_count", a_lc, 1);

        repeat (2) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
